nibble_serial_adder: RTL

//  Multi-cycle WIDTH-bit adder built around one FourBitAdder slice.

---
 rtl/nibble_serial_adder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice, one nibble per cycle, LSB first.
// Optional signed-overflow output enabled by defining NSA_OVF_EN.
module four_bit_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NSA_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_c;
  logic             last;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  four_bit_adder u_slice (
    .a_i (nib_a),
    .b_i (nib_b),
    .c_i (carry_q),
    .s_o (nib_s),
    .c_o (nib_c)
  );

  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) sum_d[4*i +: 4] = nib_s;
    end
  end

  assign last = (cnt_q == CW'(N - 1));

`ifdef NSA_OVF_EN
  logic ovf_q;
  logic msb_cin;
  // Carry into the MSB recovered from the final nibble's top sum bit.
  assign msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ nib_s[3];
  assign ovf     = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef NSA_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= nib_c;
          if (last) begin
            cout_q      <= nib_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef NSA_OVF_EN
            ovf_q       <= msb_cin ^ nib_c;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule
